microsequencer: RTL and testbench

Next-state engine for the multicycle MIPS control unit, the upstream end of the microprogram ROM. Each cycle it takes the current microinstruction's `addrctl` field and the instruction opcode, and produces the registered 4-bit `state` that addresses the microprogram ROM. The sequencing options are return-to-fetch, dispatch 1, dispatch 2 and sequential increment. It also holds the state during memory stalls, flags illegal opcodes and counts retired instructions.

---
 rtl/mips_mc_pkg.sv | 31 +++
 rtl/microsequencer_if.sv | 24 ++
 rtl/microseq_dispatch.sv | 35 +++
 rtl/microsequencer.sv | 84 ++++++++
 tb/tb_microsequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: microprogram states,
// opcodes and addrctl sequencing codes (also used by the microprogram ROM).
package mips_mc_pkg;

  typedef logic [3:0] state_t;
  typedef logic [5:0] opcode_t;
  typedef logic [1:0] addrctl_t;

  localparam state_t ST_FETCH   = 4'd0;
  localparam state_t ST_DECODE  = 4'd1;
  localparam state_t ST_MEMADR  = 4'd2;
  localparam state_t ST_MEMRD   = 4'd3;
  localparam state_t ST_MEMWB   = 4'd4;
  localparam state_t ST_MEMWR   = 4'd5;
  localparam state_t ST_RTYPEEX = 4'd6;
  localparam state_t ST_RTYPEWB = 4'd7;
  localparam state_t ST_BEQEX   = 4'd8;
  localparam state_t ST_JEX     = 4'd9;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_J     = 6'b000010;

  localparam addrctl_t ADDR_FETCH = 2'b00;
  localparam addrctl_t ADDR_DISP1 = 2'b01;
  localparam addrctl_t ADDR_DISP2 = 2'b10;
  localparam addrctl_t ADDR_SEQ   = 2'b11;

endpackage

// File: rtl/microsequencer_if.sv
// Sequencing bus between the control-unit datapath side (master) and the
// microsequencer (slave).
interface microsequencer_if #(parameter int CNT_W = 16);
  import mips_mc_pkg::*;

  addrctl_t         addrctl;
  opcode_t          opcode;
  logic             stall;
  state_t           state;
  logic             illegal_op;
  opcode_t          bad_opcode;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output addrctl, opcode, stall,
    input  state, illegal_op, bad_opcode, instr_count
  );

  modport slave (
    input  addrctl, opcode, stall,
    output state, illegal_op, bad_opcode, instr_count
  );

endinterface

// File: rtl/microseq_dispatch.sv
// Opcode dispatch tables. i_sel=0 selects dispatch 1 (from DECODE), i_sel=1
// selects dispatch 2 (from MEMADR); o_valid=0 means the opcode has no entry.
module microseq_dispatch
  import mips_mc_pkg::*;
(
  input  opcode_t i_opcode,
  input  logic    i_sel,
  output state_t  o_target,
  output logic    o_valid
);

  always_comb begin
    o_target = ST_FETCH;
    o_valid  = 1'b0;
    if (!i_sel) begin
      o_valid = 1'b1;
      case (i_opcode)
        OP_RTYPE: o_target = ST_RTYPEEX;
        OP_LW,
        OP_SW:    o_target = ST_MEMADR;
        OP_BEQ:   o_target = ST_BEQEX;
        OP_J:     o_target = ST_JEX;
        default:  o_valid  = 1'b0;
      endcase
    end else begin
      o_valid = 1'b1;
      case (i_opcode)
        OP_LW:   o_target = ST_MEMRD;
        OP_SW:   o_target = ST_MEMWR;
        default: o_valid  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram next-state engine: registered ROM address, sticky dispatch
// error capture and retired-instruction counter.
//
// state      | meaning
// FETCH   0  | instruction fetch
// DECODE  1  | register read, dispatch 1
// MEMADR  2  | address calc, dispatch 2
// MEMRD   3  | load memory read
// MEMWB   4  | load write-back
// MEMWR   5  | store memory write
// RTYPEEX 6  | ALU execute
// RTYPEWB 7  | ALU write-back
// BEQEX   8  | branch compare
// JEX     9  | jump
module microsequencer
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  microsequencer_if.slave  bus
);

  state_t           r_state;
  logic             r_illegal_op;
  opcode_t          r_bad_opcode;
  logic [CNT_W-1:0] r_instr_count;

  state_t w_disp_target;
  logic   w_disp_valid;
  state_t w_next_state;
  logic   w_disp_err;
  logic   w_retire;

  microseq_dispatch u_dispatch (
    .i_opcode (bus.opcode),
    .i_sel    (bus.addrctl == ADDR_DISP2),
    .o_target (w_disp_target),
    .o_valid  (w_disp_valid)
  );

  // Fault states 10-15 fall into the sequential error branch.
  always_comb begin
    w_next_state = ST_FETCH;
    w_disp_err   = 1'b0;
    case (bus.addrctl)
      ADDR_SEQ: begin
        if (r_state <= ST_BEQEX) w_next_state = r_state + 4'd1;
        else                     w_disp_err   = 1'b1;
      end
      ADDR_DISP1,
      ADDR_DISP2: begin
        if (w_disp_valid) w_next_state = w_disp_target;
        else              w_disp_err   = 1'b1;
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  assign w_retire = (bus.addrctl == ADDR_FETCH) && (r_state != ST_FETCH);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_FETCH;
      r_illegal_op  <= 1'b0;
      r_bad_opcode  <= '0;
      r_instr_count <= '0;
    end else if (!bus.stall) begin
      r_state <= w_next_state;
      if (w_disp_err) begin
        r_illegal_op <= 1'b1;
        if (!r_illegal_op) r_bad_opcode <= bus.opcode;
      end
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign bus.state       = r_state;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.bad_opcode  = r_bad_opcode;
  assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed instruction paths plus
// randomized addrctl/opcode/stall/reset against a table-driven reference model.
module tb_microsequencer;

  localparam int TB_W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int m_state;
  bit m_ill;
  int m_bad;
  int m_cnt;
  int d1[int];
  int d2[int];
  int legal_ops[5];

  microsequencer_if #(.CNT_W(TB_W)) bus ();

  microsequencer #(.CNT_W(TB_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void m_next(input int st, input int ac, input int op,
                                 output int ns, output bit err);
    ns  = 0;
    err = 1'b0;
    case (ac)
      0: ns = 0;
      3: if (st <= 8) ns = st + 1; else err = 1'b1;
      1: if (d1.exists(op)) ns = d1[op]; else err = 1'b1;
      default: if (d2.exists(op)) ns = d2[op]; else err = 1'b1;
    endcase
  endfunction

  task automatic m_step(input int ac, input int op, input bit st, input bit rs);
    int ns;
    bit err;
    if (rs) begin
      m_state = 0; m_ill = 1'b0; m_bad = 0; m_cnt = 0;
    end else if (!st) begin
      m_next(m_state, ac, op, ns, err);
      if (ac == 0 && m_state != 0) m_cnt = (m_cnt + 1) % (1 << TB_W);
      if (err) begin
        if (!m_ill) m_bad = op;
        m_ill = 1'b1;
      end
      m_state = ns;
    end
  endtask

  task automatic cyc(input logic [1:0] ac, input logic [5:0] op, input logic st, input logic rs);
    bus.addrctl = ac;
    bus.opcode  = op;
    bus.stall   = st;
    rst         = rs;
    @(posedge clk);
    m_step(int'(ac), int'(op), st, rs);
    #1;
    chk("model_state", 32'(bus.state), 32'(m_state));
    chk("model_ill",   32'(bus.illegal_op), 32'(m_ill));
    chk("model_bad",   32'(bus.bad_opcode), 32'(m_bad));
    chk("model_cnt",   32'(bus.instr_count), 32'(m_cnt));
  endtask

  task automatic stp(input string tag, input logic [1:0] ac, input logic [5:0] op,
                     input logic st, input int exp_state);
    cyc(ac, op, st, 1'b0);
    chk(tag, 32'(bus.state), 32'(exp_state));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    d1[0] = 6; d1[35] = 2; d1[43] = 2; d1[4] = 8; d1[2] = 9;
    d2[35] = 3; d2[43] = 5;
    legal_ops = '{0, 35, 43, 4, 2};
    m_state = 0; m_ill = 1'b0; m_bad = 0; m_cnt = 0;

    // reset state
    cyc(2'b00, 6'd0, 1'b1, 1'b1);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_ill", 32'(bus.illegal_op), 0);
    chk("rst_bad", 32'(bus.bad_opcode), 0);
    chk("rst_cnt", 32'(bus.instr_count), 0);

    // lw path
    stp("lw_s1", 2'b11, 6'b100011, 1'b0, 1);
    stp("lw_s2", 2'b01, 6'b100011, 1'b0, 2);
    stp("lw_s3", 2'b10, 6'b100011, 1'b0, 3);
    stp("lw_s4", 2'b11, 6'b100011, 1'b0, 4);
    stp("lw_s0", 2'b00, 6'b100011, 1'b0, 0);
    chk("lw_cnt", 32'(bus.instr_count), 1);

    // sw, beq, j back-to-back
    cyc(2'b00, 6'd0, 1'b0, 1'b1);
    stp("sw_s1", 2'b11, 6'b101011, 1'b0, 1);
    stp("sw_s2", 2'b01, 6'b101011, 1'b0, 2);
    stp("sw_s5", 2'b10, 6'b101011, 1'b0, 5);
    stp("sw_s0", 2'b00, 6'b101011, 1'b0, 0);
    stp("beq_s1", 2'b11, 6'b000100, 1'b0, 1);
    stp("beq_s8", 2'b01, 6'b000100, 1'b0, 8);
    stp("beq_s0", 2'b00, 6'b000100, 1'b0, 0);
    stp("j_s1", 2'b11, 6'b000010, 1'b0, 1);
    stp("j_s9", 2'b01, 6'b000010, 1'b0, 9);
    stp("j_s0", 2'b00, 6'b000010, 1'b0, 0);
    chk("seq3_cnt", 32'(bus.instr_count), 3);

    // illegal opcode, first offender kept
    stp("ill_s1", 2'b11, 6'b001000, 1'b0, 1);
    stp("ill_s0", 2'b01, 6'b001000, 1'b0, 0);
    chk("ill_flag", 32'(bus.illegal_op), 1);
    chk("ill_bad", 32'(bus.bad_opcode), 32'h08);
    stp("ill2_s1", 2'b11, 6'b111111, 1'b0, 1);
    stp("ill2_s0", 2'b01, 6'b111111, 1'b0, 0);
    chk("ill2_bad", 32'(bus.bad_opcode), 32'h08);
    chk("ill_cnt", 32'(bus.instr_count), 3);

    // stall in MEMRD, then stalled illegal dispatch
    cyc(2'b00, 6'd0, 1'b0, 1'b1);
    stp("st_s1", 2'b11, 6'b100011, 1'b0, 1);
    stp("st_s2", 2'b01, 6'b100011, 1'b0, 2);
    stp("st_s3", 2'b10, 6'b100011, 1'b0, 3);
    for (int i = 0; i < 3; i++) stp("st_hold", 2'b11, 6'b100011, 1'b1, 3);
    stp("st_s4", 2'b11, 6'b100011, 1'b0, 4);
    stp("st_s0", 2'b00, 6'b100011, 1'b0, 0);
    chk("st_cnt", 32'(bus.instr_count), 1);
    stp("sti_s1", 2'b11, 6'b111000, 1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      stp("sti_hold", 2'b01, 6'b111000, 1'b1, 1);
      chk("sti_noerr", 32'(bus.illegal_op), 0);
    end
    stp("sti_s0", 2'b01, 6'b111000, 1'b0, 0);
    chk("sti_err", 32'(bus.illegal_op), 1);
    chk("sti_bad", 32'(bus.bad_opcode), 32'h38);

    // counter wrap
    cyc(2'b00, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < (1 << TB_W) - 1; i++) begin
      cyc(2'b11, 6'b000010, 1'b0, 1'b0);
      cyc(2'b01, 6'b000010, 1'b0, 1'b0);
      cyc(2'b00, 6'b000010, 1'b0, 1'b0);
    end
    chk("wrap_full", 32'(bus.instr_count), (1 << TB_W) - 1);
    cyc(2'b11, 6'b000010, 1'b0, 1'b0);
    cyc(2'b01, 6'b000010, 1'b0, 1'b0);
    cyc(2'b00, 6'b000010, 1'b0, 1'b0);
    chk("wrap_zero", 32'(bus.instr_count), 0);

    // reset with stall in RTYPEEX
    cyc(2'b00, 6'd0, 1'b0, 1'b1);
    stp("rr_e1", 2'b11, 6'b110011, 1'b0, 1);
    stp("rr_e0", 2'b01, 6'b110011, 1'b0, 0);
    stp("rr_s1", 2'b11, 6'b000000, 1'b0, 1);
    stp("rr_s6", 2'b01, 6'b000000, 1'b0, 6);
    chk("rr_pre_ill", 32'(bus.illegal_op), 1);
    cyc(2'b11, 6'b000000, 1'b1, 1'b1);
    chk("rr_state", 32'(bus.state), 0);
    chk("rr_cnt", 32'(bus.instr_count), 0);
    chk("rr_ill", 32'(bus.illegal_op), 0);
    chk("rr_bad", 32'(bus.bad_opcode), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ac;
      logic [5:0] op;
      logic       st;
      logic       rs;
      ac = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 6'(legal_ops[$urandom_range(0, 4)]);
      else                           op = 6'($urandom_range(0, 63));
      st = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 49) == 0);
      cyc(ac, op, st, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
